// File: rtl/mul_div_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_engine_if
// Brief    : Start/Busy/Done request and result bundle for mul_div_engine.
//            The master issues operations; the slave is the engine itself.
// Revision : 1.0 - initial release
// ============================================================================
interface mul_div_engine_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic             Flush;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] ResultHi;
  logic [WIDTH-1:0] ResultLo;

  modport master (
    output Start, Op, OperandA, OperandB, Flush,
    input  Busy, Done, DivByZero, ResultHi, ResultLo
  );

  modport slave (
    input  Start, Op, OperandA, OperandB, Flush,
    output Busy, Done, DivByZero, ResultHi, ResultLo
  );
endinterface
`default_nettype wire

// File: rtl/mul_div_engine.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_engine
// Brief    : Iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU engine producing
//            the 64-bit {hi,lo} result for the HI/LO register path.
//            Ops: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_engine #(
  parameter int WIDTH = 32
) (
  input  wire logic         Clk,
  input  wire logic         Reset_n,
  mul_div_engine_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               is_div;     // latched Op[1]
  logic [2*WIDTH-1:0] acc;        // {remainder/product-hi, quotient/product-lo}
  logic [WIDTH-1:0]   divisor;    // magnitude of OperandB (multiplicand or divisor)
  logic [WIDTH-1:0]   raw_a;      // OperandA bits as sampled, for divide-by-zero Hi
  logic               neg_main;   // product sign, or quotient sign for divides
  logic               neg_rem;    // remainder sign (dividend sign)
  logic               dz_pending; // divide with a zero divisor

  logic               busy;
  logic               done;
  logic               div_by_zero;
  logic [WIDTH-1:0]   result_hi;
  logic [WIDTH-1:0]   result_lo;

  // Operand conditioning at issue: signed ops work on magnitudes.
  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // Iteration datapath and sign fix-up.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] product_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Absolute values and result signs of the operands presented at issue.
  always_comb begin
    signed_op = ~bus.Op[0];
    a_neg     = signed_op & bus.OperandA[WIDTH-1];
    b_neg     = signed_op & bus.OperandB[WIDTH-1];
    mag_a     = a_neg ? ({WIDTH{1'b0}} - bus.OperandA) : bus.OperandA;
    mag_b     = b_neg ? ({WIDTH{1'b0}} - bus.OperandB) : bus.OperandB;
  end

  // One iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : {(WIDTH+1){1'b0}});
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    trial     = rem_shift - {1'b0, divisor};
    acc_step  = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      // A set MSB on the trial difference means the divisor did not fit.
      if (trial[WIDTH]) begin
        acc_step = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end
  end

  // Restore signs on the unsigned magnitude results.
  always_comb begin
    product_fix = neg_main ? ({(2*WIDTH){1'b0}} - acc) : acc;
    quot_fix    = neg_main ? ({WIDTH{1'b0}} - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix     = neg_rem  ? ({WIDTH{1'b0}} - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_IDLE;
      count       <= '0;
      is_div      <= 1'b0;
      acc         <= '0;
      divisor     <= '0;
      raw_a       <= '0;
      neg_main    <= 1'b0;
      neg_rem     <= 1'b0;
      dz_pending  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result_hi   <= '0;
      result_lo   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // DONE lasts one cycle; a new request here issues without a bubble.
          done <= 1'b0;
          if (bus.Start && !bus.Flush) begin
            is_div     <= bus.Op[1];
            acc        <= {{WIDTH{1'b0}}, mag_a};
            divisor    <= mag_b;
            raw_a      <= bus.OperandA;
            neg_main   <= a_neg ^ b_neg;
            neg_rem    <= a_neg;
            dz_pending <= bus.Op[1] && (bus.OperandB == '0);
            count      <= '0;
            busy       <= 1'b1;
            state      <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (bus.Flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            acc   <= acc_step;
            count <= count + CW'(1);
            if (count == LAST_ITER) begin
              state <= S_FIXUP;
            end
          end
        end
        S_FIXUP: begin
          busy <= 1'b0;
          if (bus.Flush) begin
            state <= S_IDLE;
          end else begin
            if (!is_div) begin
              result_hi <= product_fix[2*WIDTH-1:WIDTH];
              result_lo <= product_fix[WIDTH-1:0];
            end else if (dz_pending) begin
              result_hi <= raw_a;
              result_lo <= {WIDTH{1'b1}};
            end else begin
              result_hi <= rem_fix;
              result_lo <= quot_fix;
            end
            div_by_zero <= dz_pending;
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.DivByZero = div_by_zero;
  assign bus.ResultHi  = result_hi;
  assign bus.ResultLo  = result_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_engine
// Brief    : Self-checking bench for mul_div_engine: directed corner cases
//            and random ops against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_engine;

  localparam int WIDTH = 32;

  logic Clk;
  logic Reset_n;
  int   n_checks;
  int   n_errors;

  mul_div_engine_if #(.WIDTH(WIDTH)) bus ();

  mul_div_engine #(.WIDTH(WIDTH)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {DivByZero, Hi, Lo} from plain 64-bit arithmetic.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: begin p = 64'(sa * sb); return {1'b0, p}; end
      2'b01: begin p = ua * ub;      return {1'b0, p}; end
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {1'b0, sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        p = {(ua % ub), 32'd0} | (ua / ub);
        return {1'b0, p[63:32], p[31:0]};
      end
    endcase
  endfunction

  logic [64:0] last_res;  // model value of the most recent completed op

  // Issue one op (inputs set away from the edge), optionally pulse a stray
  // Start mid-operation, then wait (bounded) for Done and check everything.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit stray_start);
    int          cycles;
    logic [64:0] exp;
    exp          = model(op, a, b);
    bus.Start    = 1'b1;
    bus.Op       = op;
    bus.OperandA = a;
    bus.OperandB = b;
    @(posedge Clk); #1;
    bus.Start    = 1'b0;
    bus.OperandA = $urandom;
    bus.OperandB = $urandom;
    bus.Op       = 2'($urandom_range(0, 3));
    check("busy_after_start", 64'(bus.Busy), 64'd1);
    cycles = 1;
    while (!bus.Done && cycles < 100) begin
      @(posedge Clk); #1;
      cycles++;
      bus.Start = stray_start && (cycles == 10);
    end
    bus.Start = 1'b0;
    check("latency", 64'(cycles), 64'd34);
    check("busy_in_done", 64'(bus.Busy), 64'd0);
    check("hi", 64'(bus.ResultHi), 64'(exp[63:32]));
    check("lo", 64'(bus.ResultLo), 64'(exp[31:0]));
    check("dz", 64'(bus.DivByZero), 64'(exp[64]));
    last_res = exp;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
    end
  endtask

  task automatic check_held(input string tag);
    check(tag, {bus.ResultHi, bus.ResultLo}, last_res[63:0]);
  endtask

  initial begin
    int          cyc;
    bit          saw_done;
    logic [31:0] a, b;
    n_checks     = 0;
    n_errors     = 0;
    last_res     = '0;
    bus.Start    = 1'b0;
    bus.Op       = 2'b00;
    bus.OperandA = '0;
    bus.OperandB = '0;
    bus.Flush    = 1'b0;
    Reset_n      = 1'b0;
    idle(3);
    check("reset_outputs", {29'd0, bus.Busy, bus.Done, bus.DivByZero, bus.ResultHi}, 64'd0);
    check("reset_lo", 64'(bus.ResultLo), 64'd0);
    Reset_n = 1'b1;
    idle(2);

    // Directed corner cases; several issued back-to-back from the Done cycle.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    idle(2);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'd5, 32'd0, 1'b0);
    run_op(2'b11, 32'd6, 32'd3, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1);

    // Random ops with biased operands, random gaps and stray Starts.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        2: a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run_op(2'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    // Flush at cycle 20 of a run: no Done, previous results held.
    idle(1);
    bus.Start = 1'b1; bus.Op = 2'b01; bus.OperandA = 32'd123; bus.OperandB = 32'd456;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    cyc = 1;
    while (cyc < 20) begin
      @(posedge Clk); #1;
      cyc++;
    end
    bus.Flush = 1'b1;
    @(posedge Clk); #1;
    bus.Flush = 1'b0;
    check("busy_after_flush", 64'(bus.Busy), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (bus.Done) saw_done = 1'b1;
    end
    check("no_done_after_flush", 64'(saw_done), 64'd0);
    check_held("held_after_flush");
    check("dz_held_after_flush", 64'(bus.DivByZero), 64'(last_res[64]));

    // Flush and Start together: Start is dropped.
    bus.Start = 1'b1; bus.Flush = 1'b1; bus.Op = 2'b00;
    @(posedge Clk); #1;
    bus.Start = 1'b0; bus.Flush = 1'b0;
    check("flush_beats_start", 64'(bus.Busy), 64'd0);

    // Recovery after flush.
    run_op(2'b00, 32'h1234_5678, 32'hFEDC_BA98, 1'b0);

    // Asynchronous reset mid-RUN clears outputs immediately.
    idle(1);
    bus.Start = 1'b1; bus.Op = 2'b10; bus.OperandA = 32'd99; bus.OperandB = 32'd4;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    idle(5);
    #2 Reset_n = 1'b0;
    #1;
    check("reset_mid_run", {29'd0, bus.Busy, bus.Done, bus.DivByZero, bus.ResultHi}, 64'd0);
    check("reset_mid_run_lo", 64'(bus.ResultLo), 64'd0);
    @(posedge Clk); #3;
    Reset_n = 1'b1;
    idle(2);
    run_op(2'b11, 32'd1000, 32'd33, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
